decode_queue: RTL
=================

Name: decode_queue

Overview:
Instruction buffer plus registered decoder between fetch and dispatch in the Tomasulo core. Accepts raw 32-bit RV32I words with their PC and branch prediction into a parametrised circular queue. Decodes the head entry into op/rd/rs1/rs2/imm and class flags, presented through a valid/ready output register. Supports whole-queue flush on rollback and a global stall via rdy_in.

Parameters:
DEPTH_LOG, 3, queue depth = 2**DEPTH_LOG entries (output register is extra, not counted)
ADDR_WIDTH, 32, PC width

Ports:
clk_in  input  1  clock
rst_in  input  1  asynchronous active-high reset
rdy_in  input  1  global enable; 0 freezes all state
flush  input  1  rollback; empties queue and output register
if_valid  input  1  fetch presents a word this cycle
if_inst  input  32  instruction word
if_pc  input  ADDR_WIDTH  instruction PC
if_pred_jump  input  1  fetch predicted taken
if_full  output  1  queue count == DEPTH; fetch must not present
out_valid  output  1  decoded entry valid
out_ready  input  1  dispatch accepts entry this cycle
out_op  output  7  op code from const_def.v (NULL for unknown)
out_rd / out_rs1 / out_rs2  output  5 each  register indices
out_imm  output  32  decoded immediate
out_pc  output  ADDR_WIDTH  PC of entry
out_pred_jump  output  1  prediction of entry
out_is_branch  output  1  B_type
out_is_j_type  output  1  JAL, JALR or B_type
out_is_load_store  output  1  L_type or S_type
out_illegal  output  1  see Optional Feature

Behaviour:
- Reset (async): head=tail=count=0, out_valid=0, all out_* fields 0, if_full=0.
- rdy_in=0: no enqueue, no pop, no flush; all registers hold.
- Enqueue: if_valid && count<DEPTH writes {inst,pc,pred} at tail, tail wraps mod DEPTH. if_valid while full: word dropped, state unchanged.
- if_full combinational from count only (not from same-cycle pop).
- Pop: when count>0 and (!out_valid || out_ready), head decoded into output register, out_valid=1 next edge, head wraps. If out_ready && count==0, out_valid clears.
- Same-cycle enqueue and pop: count unchanged.
- Latency: word enqueued at edge k to empty queue with free output register appears at out_* after edge k+1. Throughput 1/cycle.
- Flush (rdy_in=1): next edge count=0, head=tail, out_valid=0; flush beats same-cycle enqueue/pop (incoming word dropped).
- Opcode map inst[6:0]: 0110011 R, 0010011 I, 0000011 L, 0100011 S, 1100011 B, 1101111 JAL, 1100111 JALR, 0110111 LUI, 0010111 AUIPC; else op=NULL, flags 0.
- SUB/SRA/SRAI selected by inst[30] only.
- Imm: I/L/JALR sign-ext inst[31:20]; SLLI/SRLI/SRAI zero-ext inst[24:20]; S {sext inst[31:25],inst[11:7]}; B {sext inst[31],inst[7],inst[30:25],inst[11:8],0}; JAL {sext inst[31],inst[19:12],inst[20],inst[30:21],0}; LUI/AUIPC {inst[31:12],12'b0}; R 0.
- Index forcing: rd=0 for S/B; rs1=0 for LUI/AUIPC/JAL; rs2=0 unless R/S/B; otherwise raw fields.

Optional Feature:
DECODE_ILLEGAL_CHECK_EN defined: out_illegal=1 (registered with entry) for unknown opcode; L funct3 in {011,110,111}; S funct3 >= 011; B funct3 in {010,011}; JALR funct3 != 000; R or SLLI/SRLI/SRAI with inst[31:25] not 0000000/0100000 (0100000 legal only for SUB/SRA/SRAI); illegal entries carry op=NULL. Undefined: out_illegal tied 0, decode otherwise identical.

Test Plan:
Reset, enqueue 0x00500093 pc 0x0 -> after next edge out_valid=1, op=ADDI, rd=1, rs1=0, rs2=0, imm=5.
DEPTH_LOG=3, out_ready=0, 10 valid words -> 9 accepted (1 in output reg + 8 queued), if_full=1, 10th dropped; one out_ready cycle -> if_full=0 next cycle.
5 entries queued, flush with if_valid=1 -> next cycle out_valid=0, if_full=0, no stale entry ever appears.
0x123452B7 -> LUI, rd=5, rs1=0, imm=0x12345000; 0xFE208EE3 -> BEQ, rd=0, rs1=1, rs2=2, imm=0xFFFFFFFC, is_branch=1, is_j_type=1.
0x4041D193 -> SRAI, rd=3, rs1=3, imm=4; rdy_in=0 for 3 cycles with out_ready=1 -> outputs and count held.
0x0000007F -> op=NULL; out_illegal=1 with DECODE_ILLEGAL_CHECK_EN, 0 without.

Source files
------------

// File: rtl/decode_queue.sv
`default_nettype none
// ============================================================================
// Module      : decode_queue
// Description : Instruction buffer and registered RV32I decoder between
//               fetch and dispatch. Raw words with PC and prediction enter a
//               circular queue. The head entry is decoded into a valid/ready
//               output register. Supports whole-queue flush and a global
//               stall through rdy_in.
//               Optional build macro: DECODE_ILLEGAL_CHECK_EN enables the
//               illegal-encoding check. When the macro is undefined,
//               out_illegal is tied low.
// Revision    : 1.0 - initial release
// ============================================================================
module decode_queue #(
    parameter int DEPTH_LOG  = 3,
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    input  logic                  rdy_in,
    input  logic                  flush,
    input  logic                  if_valid,
    input  logic [31:0]           if_inst,
    input  logic [ADDR_WIDTH-1:0] if_pc,
    input  logic                  if_pred_jump,
    output logic                  if_full,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [6:0]            out_op,
    output logic [4:0]            out_rd,
    output logic [4:0]            out_rs1,
    output logic [4:0]            out_rs2,
    output logic [31:0]           out_imm,
    output logic [ADDR_WIDTH-1:0] out_pc,
    output logic                  out_pred_jump,
    output logic                  out_is_branch,
    output logic                  out_is_j_type,
    output logic                  out_is_load_store,
    output logic                  out_illegal
);

    localparam int DEPTH = 1 << DEPTH_LOG;
    localparam logic [DEPTH_LOG:0]   FULL_COUNT = (DEPTH_LOG + 1)'(DEPTH);
    localparam logic [DEPTH_LOG:0]   COUNT_ONE  = (DEPTH_LOG + 1)'(1);
    localparam logic [DEPTH_LOG-1:0] PTR_ONE    = DEPTH_LOG'(1);

    // Major opcodes (inst[6:0])
    localparam logic [6:0] OPC_R     = 7'b0110011;
    localparam logic [6:0] OPC_I     = 7'b0010011;
    localparam logic [6:0] OPC_L     = 7'b0000011;
    localparam logic [6:0] OPC_S     = 7'b0100011;
    localparam logic [6:0] OPC_B     = 7'b1100011;
    localparam logic [6:0] OPC_JAL   = 7'b1101111;
    localparam logic [6:0] OPC_JALR  = 7'b1100111;
    localparam logic [6:0] OPC_LUI   = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC = 7'b0010111;

    // Core-wide operation codes presented on out_op
    localparam logic [6:0] OP_NULL  = 7'd0;
    localparam logic [6:0] OP_LUI   = 7'd1;
    localparam logic [6:0] OP_AUIPC = 7'd2;
    localparam logic [6:0] OP_JAL   = 7'd3;
    localparam logic [6:0] OP_JALR  = 7'd4;
    localparam logic [6:0] OP_BEQ   = 7'd5;
    localparam logic [6:0] OP_BNE   = 7'd6;
    localparam logic [6:0] OP_BLT   = 7'd7;
    localparam logic [6:0] OP_BGE   = 7'd8;
    localparam logic [6:0] OP_BLTU  = 7'd9;
    localparam logic [6:0] OP_BGEU  = 7'd10;
    localparam logic [6:0] OP_LB    = 7'd11;
    localparam logic [6:0] OP_LH    = 7'd12;
    localparam logic [6:0] OP_LW    = 7'd13;
    localparam logic [6:0] OP_LBU   = 7'd14;
    localparam logic [6:0] OP_LHU   = 7'd15;
    localparam logic [6:0] OP_SB    = 7'd16;
    localparam logic [6:0] OP_SH    = 7'd17;
    localparam logic [6:0] OP_SW    = 7'd18;
    localparam logic [6:0] OP_ADDI  = 7'd19;
    localparam logic [6:0] OP_SLTI  = 7'd20;
    localparam logic [6:0] OP_SLTIU = 7'd21;
    localparam logic [6:0] OP_XORI  = 7'd22;
    localparam logic [6:0] OP_ORI   = 7'd23;
    localparam logic [6:0] OP_ANDI  = 7'd24;
    localparam logic [6:0] OP_SLLI  = 7'd25;
    localparam logic [6:0] OP_SRLI  = 7'd26;
    localparam logic [6:0] OP_SRAI  = 7'd27;
    localparam logic [6:0] OP_ADD   = 7'd28;
    localparam logic [6:0] OP_SUB   = 7'd29;
    localparam logic [6:0] OP_SLL   = 7'd30;
    localparam logic [6:0] OP_SLT   = 7'd31;
    localparam logic [6:0] OP_SLTU  = 7'd32;
    localparam logic [6:0] OP_XOR   = 7'd33;
    localparam logic [6:0] OP_SRL   = 7'd34;
    localparam logic [6:0] OP_SRA   = 7'd35;
    localparam logic [6:0] OP_OR    = 7'd36;
    localparam logic [6:0] OP_AND   = 7'd37;

    // Queue storage and pointers
    logic [31:0]           r_inst_mem [DEPTH];
    logic [ADDR_WIDTH-1:0] r_pc_mem   [DEPTH];
    logic [DEPTH-1:0]      r_pred_mem;
    logic [DEPTH_LOG-1:0]  r_head;
    logic [DEPTH_LOG-1:0]  r_tail;
    logic [DEPTH_LOG:0]    r_count;

    // Control
    logic w_enq;
    logic w_pop;
    logic w_drain;

    // Decode of the head entry
    logic [31:0] w_inst;
    logic [6:0]  w_opcode;
    logic [2:0]  w_funct3;
    logic [6:0]  w_op;
    logic [6:0]  w_op_final;
    logic [4:0]  w_rd;
    logic [4:0]  w_rs1;
    logic [4:0]  w_rs2;
    logic [31:0] w_imm;
    logic        w_is_branch;
    logic        w_is_j_type;
    logic        w_is_load_store;
    logic        w_illegal;

    assign if_full  = (r_count == FULL_COUNT);
    // A stalled cycle or a flush cycle blocks both ends of the queue.
    assign w_enq    = rdy_in && !flush && if_valid && !if_full;
    assign w_pop    = rdy_in && !flush && (r_count != '0) && (!out_valid || out_ready);
    assign w_drain  = rdy_in && !flush && out_valid && out_ready;

    assign w_inst   = r_inst_mem[r_head];
    assign w_opcode = w_inst[6:0];
    assign w_funct3 = w_inst[14:12];

    // Write incoming words at the tail. The payload needs no reset because count gates reads.
    always_ff @(posedge clk_in) begin
        if (w_enq) begin
            r_inst_mem[r_tail] <= if_inst;
            r_pc_mem[r_tail]   <= if_pc;
            r_pred_mem[r_tail] <= if_pred_jump;
        end
    end

    // Update the head, tail and occupancy count. A flush collapses the queue to empty.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else if (rdy_in) begin
            if (flush) begin
                r_head  <= r_tail;
                r_count <= '0;
            end else begin
                if (w_enq) r_tail <= r_tail + PTR_ONE;
                if (w_pop) r_head <= r_head + PTR_ONE;
                if (w_enq && !w_pop)      r_count <= r_count + COUNT_ONE;
                else if (!w_enq && w_pop) r_count <= r_count - COUNT_ONE;
            end
        end
    end

    // Decode the head word into operation, indices, immediate and class flags.
    always_comb begin
        w_op            = OP_NULL;
        w_rd            = w_inst[11:7];
        w_rs1           = w_inst[19:15];
        w_rs2           = 5'd0;
        w_imm           = 32'd0;
        w_is_branch     = 1'b0;
        w_is_j_type     = 1'b0;
        w_is_load_store = 1'b0;
        case (w_opcode)
            OPC_R: begin
                w_rs2 = w_inst[24:20];
                case (w_funct3)
                    3'b000:  w_op = w_inst[30] ? OP_SUB : OP_ADD;
                    3'b001:  w_op = OP_SLL;
                    3'b010:  w_op = OP_SLT;
                    3'b011:  w_op = OP_SLTU;
                    3'b100:  w_op = OP_XOR;
                    3'b101:  w_op = w_inst[30] ? OP_SRA : OP_SRL;
                    3'b110:  w_op = OP_OR;
                    default: w_op = OP_AND;
                endcase
            end
            OPC_I: begin
                w_imm = {{20{w_inst[31]}}, w_inst[31:20]};
                case (w_funct3)
                    3'b000:  w_op = OP_ADDI;
                    3'b010:  w_op = OP_SLTI;
                    3'b011:  w_op = OP_SLTIU;
                    3'b100:  w_op = OP_XORI;
                    3'b110:  w_op = OP_ORI;
                    3'b111:  w_op = OP_ANDI;
                    3'b001: begin
                        w_op  = OP_SLLI;
                        w_imm = {27'd0, w_inst[24:20]};
                    end
                    default: begin
                        w_op  = w_inst[30] ? OP_SRAI : OP_SRLI;
                        w_imm = {27'd0, w_inst[24:20]};
                    end
                endcase
            end
            OPC_L: begin
                w_is_load_store = 1'b1;
                w_imm = {{20{w_inst[31]}}, w_inst[31:20]};
                case (w_funct3)
                    3'b000:  w_op = OP_LB;
                    3'b001:  w_op = OP_LH;
                    3'b010:  w_op = OP_LW;
                    3'b100:  w_op = OP_LBU;
                    3'b101:  w_op = OP_LHU;
                    default: w_op = OP_NULL;
                endcase
            end
            OPC_S: begin
                w_is_load_store = 1'b1;
                w_rd  = 5'd0;
                w_rs2 = w_inst[24:20];
                w_imm = {{20{w_inst[31]}}, w_inst[31:25], w_inst[11:7]};
                case (w_funct3)
                    3'b000:  w_op = OP_SB;
                    3'b001:  w_op = OP_SH;
                    3'b010:  w_op = OP_SW;
                    default: w_op = OP_NULL;
                endcase
            end
            OPC_B: begin
                w_is_branch = 1'b1;
                w_is_j_type = 1'b1;
                w_rd  = 5'd0;
                w_rs2 = w_inst[24:20];
                w_imm = {{20{w_inst[31]}}, w_inst[7], w_inst[30:25], w_inst[11:8], 1'b0};
                case (w_funct3)
                    3'b000:  w_op = OP_BEQ;
                    3'b001:  w_op = OP_BNE;
                    3'b100:  w_op = OP_BLT;
                    3'b101:  w_op = OP_BGE;
                    3'b110:  w_op = OP_BLTU;
                    3'b111:  w_op = OP_BGEU;
                    default: w_op = OP_NULL;
                endcase
            end
            OPC_JAL: begin
                w_op        = OP_JAL;
                w_is_j_type = 1'b1;
                w_rs1       = 5'd0;
                w_imm = {{12{w_inst[31]}}, w_inst[19:12], w_inst[20], w_inst[30:21], 1'b0};
            end
            OPC_JALR: begin
                w_op        = OP_JALR;
                w_is_j_type = 1'b1;
                w_imm       = {{20{w_inst[31]}}, w_inst[31:20]};
            end
            OPC_LUI: begin
                w_op  = OP_LUI;
                w_rs1 = 5'd0;
                w_imm = {w_inst[31:12], 12'd0};
            end
            OPC_AUIPC: begin
                w_op  = OP_AUIPC;
                w_rs1 = 5'd0;
                w_imm = {w_inst[31:12], 12'd0};
            end
            default: begin
                w_op = OP_NULL;
            end
        endcase
    end

`ifdef DECODE_ILLEGAL_CHECK_EN
    // Flag encodings outside RV32I. Bit 30 selects only SUB/SRA/SRAI.
    always_comb begin
        w_illegal = 1'b0;
        case (w_opcode)
            OPC_R: begin
                w_illegal = !((w_inst[31:25] == 7'b0000000) ||
                              ((w_inst[31:25] == 7'b0100000) &&
                               ((w_funct3 == 3'b000) || (w_funct3 == 3'b101))));
            end
            OPC_I: begin
                if (w_funct3 == 3'b001)
                    w_illegal = (w_inst[31:25] != 7'b0000000);
                else if (w_funct3 == 3'b101)
                    w_illegal = !((w_inst[31:25] == 7'b0000000) ||
                                  (w_inst[31:25] == 7'b0100000));
            end
            OPC_L:     w_illegal = (w_funct3 == 3'b011) || (w_funct3 == 3'b110) ||
                                   (w_funct3 == 3'b111);
            OPC_S:     w_illegal = (w_funct3 >= 3'b011);
            OPC_B:     w_illegal = (w_funct3 == 3'b010) || (w_funct3 == 3'b011);
            OPC_JALR:  w_illegal = (w_funct3 != 3'b000);
            OPC_JAL, OPC_LUI, OPC_AUIPC: w_illegal = 1'b0;
            default:   w_illegal = 1'b1;
        endcase
    end
    assign w_op_final = w_illegal ? OP_NULL : w_op;
`else
    assign w_illegal  = 1'b0;
    assign w_op_final = w_op;
`endif

    // Output register: load on pop, drop when consumed with nothing behind it, clear on flush.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            out_valid         <= 1'b0;
            out_op            <= OP_NULL;
            out_rd            <= 5'd0;
            out_rs1           <= 5'd0;
            out_rs2           <= 5'd0;
            out_imm           <= 32'd0;
            out_pc            <= '0;
            out_pred_jump     <= 1'b0;
            out_is_branch     <= 1'b0;
            out_is_j_type     <= 1'b0;
            out_is_load_store <= 1'b0;
            out_illegal       <= 1'b0;
        end else if (rdy_in) begin
            if (flush) begin
                out_valid <= 1'b0;
            end else if (w_pop) begin
                out_valid         <= 1'b1;
                out_op            <= w_op_final;
                out_rd            <= w_rd;
                out_rs1           <= w_rs1;
                out_rs2           <= w_rs2;
                out_imm           <= w_imm;
                out_pc            <= r_pc_mem[r_head];
                out_pred_jump     <= r_pred_mem[r_head];
                out_is_branch     <= w_is_branch;
                out_is_j_type     <= w_is_j_type;
                out_is_load_store <= w_is_load_store;
                out_illegal       <= w_illegal;
            end else if (w_drain) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire
